// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
`timescale 1ns/1ps
interface pipelined_addsub_if #(
   parameter int unsigned LEN = 32
);
   logic           i_valid;
   logic           o_ready;
   logic [LEN-1:0] i_a;
   logic [LEN-1:0] i_b;
   logic           i_sub;
   logic           i_signed;
   logic           i_flush;
   logic           o_valid;
   logic           i_ready;
   logic [LEN-1:0] o_result;
   logic           o_carry;
   logic           o_overflow;
   logic           o_zero;

   modport slave (
      input  i_valid, i_a, i_b, i_sub, i_signed, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
   );

   modport master (
      output i_valid, i_a, i_b, i_sub, i_signed, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined LEN-bit add/subtract: one SEG-bit ripple slice per stage, carry registered between stages.
// Flags are formed in the last stage; the whole pipe stalls as one unit on output backpressure.
`timescale 1ns/1ps
module pipelined_addsub #(
   parameter int unsigned LEN    = 32,
   parameter int unsigned STAGES = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int unsigned SEG  = LEN / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   if ((STAGES < 1) || ((LEN % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_addsub: LEN must be a non-zero multiple of STAGES");
   end

   // Per-stage registers: operands still to be summed, partial result, carry and mode.
   logic [STAGES-1:0] vld_q;
   logic [LEN-1:0]    a_q   [STAGES];
   logic [LEN-1:0]    bx_q  [STAGES];
   logic [LEN-1:0]    res_q [STAGES];
   logic              cry_q [STAGES];
   logic              sub_q [STAGES];
   logic              sgn_q [STAGES];
   logic              ovf_q;
   logic              zero_q;

   logic [LEN-1:0]    in_a    [STAGES];
   logic [LEN-1:0]    in_bx   [STAGES];
   logic [LEN-1:0]    in_res  [STAGES];
   logic              in_cin  [STAGES];
   logic              in_sub  [STAGES];
   logic              in_sgn  [STAGES];
   logic [LEN-1:0]    res_d   [STAGES];
   logic              cry_d   [STAGES];
   logic [SEG:0]      slice_c [STAGES];
   logic              msb_cin_c;
   logic              ovf_d;
   logic              zero_d;
   logic              adv_c;
   logic              acc_c;

   assign adv_c = ~vld_q[LAST] | bus.i_ready;
   assign acc_c = bus.i_valid & adv_c & ~bus.i_flush;

   // Stage inputs, slice sums and last-stage flags.
   always_comb begin
      in_a[0]   = bus.i_a;
      in_bx[0]  = bus.i_sub ? ~bus.i_b : bus.i_b;
      in_res[0] = '0;
      in_cin[0] = bus.i_sub;
      in_sub[0] = bus.i_sub;
      in_sgn[0] = bus.i_signed;
      for (int unsigned k = 1; k < STAGES; k++) begin
         in_a[k]   = a_q[k-1];
         in_bx[k]  = bx_q[k-1];
         in_res[k] = res_q[k-1];
         in_cin[k] = cry_q[k-1];
         in_sub[k] = sub_q[k-1];
         in_sgn[k] = sgn_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_c[k] = {1'b0, in_a[k][k*SEG +: SEG]} + {1'b0, in_bx[k][k*SEG +: SEG]}
                      + (SEG+1)'(in_cin[k]);
         res_d[k]   = in_res[k];
         res_d[k][k*SEG +: SEG] = slice_c[k][SEG-1:0];
         cry_d[k]   = slice_c[k][SEG];
      end
      // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
      msb_cin_c = in_a[LAST][LEN-1] ^ in_bx[LAST][LEN-1] ^ res_d[LAST][LEN-1];
      if (in_sgn[LAST]) begin
         ovf_d = msb_cin_c ^ cry_d[LAST];
      end else begin
         ovf_d = in_sub[LAST] ? ~cry_d[LAST] : cry_d[LAST];
      end
      zero_d = (res_d[LAST] == '0);
   end

   // Pipe registers; flush kills every valid bit and beats both stall and accept.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            bx_q[k]  <= '0;
            res_q[k] <= '0;
            cry_q[k] <= 1'b0;
            sub_q[k] <= 1'b0;
            sgn_q[k] <= 1'b0;
         end
      end else if (bus.i_flush) begin
         vld_q <= '0;
      end else if (adv_c) begin
         vld_q[0] <= acc_c;
         for (int unsigned k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]   <= in_a[k];
            bx_q[k]  <= in_bx[k];
            res_q[k] <= res_d[k];
            cry_q[k] <= cry_d[k];
            sub_q[k] <= in_sub[k];
            sgn_q[k] <= in_sgn[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.o_ready    = adv_c;
   assign bus.o_valid    = vld_q[LAST];
   assign bus.o_result   = res_q[LAST];
   assign bus.o_carry    = cry_q[LAST];
   assign bus.o_overflow = ovf_q;
   assign bus.o_zero     = zero_q;
endmodule
